// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI Mode 0 target.
package spi_pkg;
  localparam int SPI_BITS = 8;

  typedef logic [SPI_BITS-1:0] spi_byte_t;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spis_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with registered-history rise/fall detect.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;
endmodule

// File: rtl/spi_slave.sv
// SPI Mode 0 target on the system clock; optional frame_err via SPI_SLAVE_FRAME_ERR_EN.
// IDLE   | deselected, MISO pad off, bit counter parked at 7
// ACTIVE | selected, shifting on synchronised SCLK edges
module spi_slave
  import spi_pkg::*;
#(
  parameter int        SYNC_STAGES = 2,
  parameter spi_byte_t DEFAULT_TX  = 8'hFF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sclk,
  input  logic      cs_n,
  input  logic      mosi,
  output logic      miso,
  output logic      miso_oe,
  input  spi_byte_t tx_data,
  input  logic      tx_valid,
  output logic      tx_ready,
  output spi_byte_t rx_data,
  output logic      rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic      frame_err,
`endif
  output logic      busy
);
  localparam logic [2:0] LAST_BIT = 3'(SPI_BITS - 1);

  spis_state_t r_state, w_state_nxt;

  logic                   w_sclk_s, w_sclk_rise, w_sclk_fall;
  logic                   w_cs_s, w_cs_rise, w_cs_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi_s;

  logic [2:0] r_bit_cnt;
  logic       r_reload;
  spi_byte_t  r_rx_shift, r_tx_shift, r_rx_data, r_hold;
  logic       r_hold_full, r_rx_valid, r_miso;
  logic       w_load, w_wr;
  spi_byte_t  w_load_byte;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .i_async(sclk),
    .o_sync(w_sclk_s), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .i_async(cs_n),
    .o_sync(w_cs_s), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mosi_sync <= '0;
    else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = ACTIVE;
          w_load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_cs_rise)                     w_state_nxt = IDLE;
        else if (w_sclk_fall && r_reload)  w_load      = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load_byte = r_hold_full ? r_hold : DEFAULT_TX;
  // A write is only accepted into an empty hold, so it never races a load that empties it.
  assign w_wr        = tx_valid & ~r_hold_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_hold      <= '0;
    end else if (w_load && r_hold_full) begin
      r_hold_full <= 1'b0;
    end else if (w_wr) begin
      r_hold_full <= 1'b1;
      r_hold      <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt  <= LAST_BIT;
      r_reload   <= 1'b0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_load) begin
        r_tx_shift <= w_load_byte;
        r_miso     <= w_load_byte[SPI_BITS-1];
      end
      if (r_state == IDLE || w_cs_rise) begin
        r_bit_cnt <= LAST_BIT;
        r_reload  <= 1'b0;
      end else if (w_sclk_rise) begin
        r_rx_shift <= {r_rx_shift[SPI_BITS-2:0], w_mosi_s};
        if (r_bit_cnt == 3'd0) begin
          r_rx_data  <= {r_rx_shift[SPI_BITS-2:0], w_mosi_s};
          r_rx_valid <= 1'b1;
          r_bit_cnt  <= LAST_BIT;
          r_reload   <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt - 3'd1;
        end
      end else if (w_sclk_fall) begin
        if (r_reload) begin
          r_reload <= 1'b0;
        end else begin
          r_tx_shift <= {r_tx_shift[SPI_BITS-2:0], 1'b0};
          r_miso     <= r_tx_shift[SPI_BITS-2];
        end
      end
    end
  end

`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic r_bit_seen, r_frame_err, w_frame_err;

  // Tracks whether the current byte has seen any SCLK rise, so a deselect right at a boundary is clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_bit_seen <= 1'b0;
    else if (r_state == IDLE || w_cs_rise)   r_bit_seen <= 1'b0;
    else if (w_sclk_rise)                    r_bit_seen <= (r_bit_cnt != 3'd0);
  end

  assign w_frame_err =
      ((r_state == ACTIVE) && w_cs_rise &&
       ((r_bit_cnt != LAST_BIT) || (!r_reload && r_bit_seen))) ||
      ((r_state == IDLE) && w_cs_fall && w_sclk_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_err <= 1'b0;
    else        r_frame_err <= w_frame_err;
  end

  assign frame_err = r_frame_err;

  logic w_unused;
  assign w_unused = w_cs_s;
`else
  logic w_unused;
  assign w_unused = w_cs_s ^ w_sclk_s;
`endif

  assign miso     = r_miso;
  assign miso_oe  = (r_state == ACTIVE);
  assign busy     = (r_state == ACTIVE);
  assign tx_ready = ~r_hold_full;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
endmodule

// File: tb/tb_spi_slave.sv
// Directed + random bench for spi_slave: bench-side SPI master, queue model of the TX hold path.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int HALF = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic       tx_valid = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
`endif

  int errors = 0, checks = 0;
  int rx_pulses = 0, ferr_pulses = 0;
  logic [7:0] rx_seen[$];
  logic [7:0] hold_q[$];
  logic [7:0] f_mo[16];
  logic [7:0] f_wb[16];
  bit         f_wen[16];
  logic [7:0] mi;
  int         pulses_before, ferr_exp;

  spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLAVE_FRAME_ERR_EN
    .frame_err(frame_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        rx_seen.push_back(rx_data);
        rx_pulses++;
      end
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err) ferr_pulses++;
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Every byte load in the target takes the pending hold byte, or DEFAULT_TX when none is pending.
  function automatic logic [7:0] model_load();
    if (hold_q.size() > 0) return hold_q.pop_front();
    return 8'hFF;
  endfunction

  task automatic client_write(input logic [7:0] b);
    int n;
    n = 0;
    while (!tx_ready && n < 200) begin
      wait_clk(1);
      n++;
    end
    if (!tx_ready) begin
      check("tx_ready_timeout", 32'd0, 32'd1);
    end else begin
      tx_data  = b;
      tx_valid = 1'b1;
      wait_clk(1);
      tx_valid = 1'b0;
      hold_q.push_back(b);
    end
  endtask

  task automatic xfer(input logic [7:0] mo, input bit wen, input logic [7:0] wb,
                      output logic [7:0] got);
    for (int i = 7; i >= 0; i--) begin
      mosi = mo[i];
      if (i == 3 && wen) client_write(wb);
      wait_clk(HALF);
      got[i] = miso;
      sclk   = 1'b1;
      wait_clk(HALF);
      sclk   = 1'b0;
    end
  endtask

  task automatic run_frame(input int n);
    logic [7:0] exp_load, got;
    exp_load = model_load();
    cs_n = 1'b0;
    wait_clk(HALF);
    check("busy_active", 32'(busy), 32'd1);
    check("oe_active", 32'(miso_oe), 32'd1);
    check("tx_ready_after_load", 32'(tx_ready), 32'(hold_q.size() == 0));
    for (int k = 0; k < n; k++) begin
      xfer(f_mo[k], f_wen[k], f_wb[k], got);
      check("miso_byte", 32'(got), 32'(exp_load));
      exp_load = model_load();
    end
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(HALF + 3);
    check("busy_idle", 32'(busy), 32'd0);
    check("oe_idle", 32'(miso_oe), 32'd0);
  endtask

  task automatic check_rx(input int n);
    check("rx_count", 32'(rx_seen.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < rx_seen.size()) check("rx_byte", 32'(rx_seen[i]), 32'(f_mo[i]));
    rx_seen.delete();
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 16; i++) begin
      f_wen[i] = 1'b0;
      f_wb[i]  = 8'h00;
      f_mo[i]  = 8'h00;
    end
  endtask

  initial begin
    ferr_exp = 0;
    clear_frame();
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // single byte with preload
    client_write(8'hA5);
    check("tx_ready_full", 32'(tx_ready), 32'd0);
    f_mo[0] = 8'h3C;
    run_frame(1);
    check_rx(1);
    check("rx_data_hold", 32'(rx_data), 32'h3C);

    // underrun
    clear_frame();
    f_mo[0] = 8'h81;
    run_frame(1);
    check_rx(1);

    // two bytes, second written mid byte 1
    clear_frame();
    client_write(8'h12);
    f_mo[0] = 8'hDE; f_mo[1] = 8'hAD;
    f_wen[0] = 1'b1; f_wb[0] = 8'h34;
    run_frame(2);
    check_rx(2);

    // aborted after 5 bits
    clear_frame();
    pulses_before = rx_pulses;
    void'(model_load());
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      wait_clk(HALF); sclk = 1'b1;
      wait_clk(HALF); sclk = 1'b0;
    end
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(HALF + 3);
    check("abort_no_rx", 32'(rx_pulses), 32'(pulses_before));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oe", 32'(miso_oe), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ferr_exp++;
`endif
    check("abort_frame_err", 32'(ferr_pulses), 32'(ferr_exp));
    rx_seen.delete();
    f_mo[0] = 8'h55;
    run_frame(1);
    check_rx(1);

    // reset during byte 1, bit 3
    clear_frame();
    client_write(8'h77);
    void'(model_load());
    cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      wait_clk(HALF); sclk = 1'b1;
      wait_clk(HALF); sclk = 1'b0;
    end
    client_write(8'h66);
    rst_n = 1'b0;
    cs_n  = 1'b1; sclk = 1'b0; mosi = 1'b0;
    wait_clk(1);
    hold_q.delete();
    check("mid_rst_miso", 32'(miso), 32'd0);
    check("mid_rst_oe", 32'(miso_oe), 32'd0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_rx_data", 32'(rx_data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_clk(4);
    rx_seen.delete();
    f_mo[0] = 8'hC3;
    run_frame(1);
    check_rx(1);

    // SCLK toggling while deselected
    pulses_before = rx_pulses;
    for (int i = 0; i < 16; i++) begin
      mosi = 1'($urandom);
      wait_clk(HALF); sclk = 1'b1;
      wait_clk(HALF); sclk = 1'b0;
    end
    wait_clk(HALF);
    check("idle_sclk_no_rx", 32'(rx_pulses), 32'(pulses_before));
    check("idle_sclk_busy", 32'(busy), 32'd0);

    // random: 4 frames x 4 bytes each way
    for (int f = 0; f < 4; f++) begin
      clear_frame();
      if ($urandom_range(0, 3) != 0) client_write(8'($urandom));
      for (int k = 0; k < 4; k++) begin
        f_mo[k]  = 8'($urandom);
        f_wen[k] = ($urandom_range(0, 3) != 0);
        f_wb[k]  = 8'($urandom);
      end
      run_frame(4);
      check_rx(4);
    end
    check("frame_err_total", 32'(ferr_pulses), 32'(ferr_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
